i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
Shares one I2C master's 32-bit register port between NUM_REQ requesters.
- Round-robin grant among requesters; latches the winner's transaction (7-bit slave address, R/W, 8-bit write data).
- Programs the master's registers, starts it, polls the status done bit, fetches receive data on reads, cleans up, returns a one-cycle response.
- Sits between the software/peripheral requesters and the I2C master instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLK_DIV_VAL, 8'd8, value written to the master clock-divider register every transaction.
- TIMEOUT_CYCLES, 16'd65535, poll-cycle budget before abort; used only with I2C_ARB_TIMEOUT_EN.
- ID_W, $clog2(NUM_REQ), requester id width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  level request per requester; held until its response.
- req_addr  in  NUM_REQ*7  slave address per requester; slice i = [7i+6:7i].
- req_rw  in  NUM_REQ  0 = write, 1 = read.
- req_wdata  in  NUM_REQ*8  write byte per requester.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  ID_W  requester served.
- rsp_rdata  out  8  received byte; 0 for writes.
- rsp_err  out  1  timeout abort.
- busy  out  1  high in every state except IDLE.
- m_wr  out  1  master register write strobe; 0 = read.
- m_addr_offset  out  8  master register offset.
- m_data_in  out  32  master write data.
- m_data_out  in  32  master read data; registered, valid one cycle after offset is presented with m_wr=0.

Behaviour:
Master register map:
- 0x00 start
- 0x04 clk_div
- 0x08 slave_addr
- 0x0C tx data
- 0x10 rx data
- 0x14 status (bit0 = done)
- 0x18 mode (1 = read)

Reset: all outputs 0, state IDLE, rr pointer 0, latched fields 0.

State machine; each write state drives m_wr=1 for exactly one cycle:
- IDLE: if any req, grant first asserted index at or after the rr pointer (wrapping). Latch id, addr, rw, wdata. Set pointer = id+1 mod NUM_REQ. Go to W_DIV. With no req, hold m_wr=0, offset 0x14.
- W_DIV: 0x04 <= CLK_DIV_VAL.
- W_ADDR: 0x08 <= {25'd0, addr}.
- W_DATA: 0x0C <= {24'd0, wdata}; written for reads too.
- W_MODE: 0x18 <= {31'd0, rw}.
- W_CLR: 0x14 <= 0.
- W_START: 0x00 <= 1. Clear the timeout counter.
- POLL: m_wr=0, offset 0x14, held through POLL_CHK.
- POLL_CHK: if m_data_out[0], go to RD_REQ when rw=1, else W_STOP. Otherwise return to POLL and increment the timeout counter.
- RD_REQ: offset 0x10, m_wr=0.
- RD_CAP: rdata <= m_data_out[7:0].
- W_STOP: 0x00 <= 0.
- W_DONECLR: 0x14 <= 0.
- RESP: rsp_valid=1 with rsp_id, rsp_rdata, rsp_err for one cycle; then IDLE.

Latency and ordering:
- Grant to first bus write: 1 cycle.
- Write transaction, done seen on first poll: 11 cycles from IDLE exit to rsp_valid.
- Whenever m_wr=0 outside POLL/RD_REQ, offset = 0x14 and m_data_in = 0.

Boundary conditions:
- A requester dropping req mid-transaction does not abort; the response is still issued.
- A req asserted during RESP is arbitrated in the next IDLE cycle.
- Only one transaction is ever in flight.
- All requesters asserted continuously are served in order 0, 1, 2, 3, 0, ...
- Async reset mid-transaction returns to IDLE immediately; master registers are left as-is and the next transaction rewrites all of them.

Optional Feature:
I2C_ARB_TIMEOUT_EN
- Defined: a 16-bit counter counts POLL_CHK misses. When it reaches TIMEOUT_CYCLES, set err=1, rdata=0, and go to W_STOP (skipping the read).
- Not defined: no counter; poll indefinitely; rsp_err tied 0.

Decomposition:
- Package i2c_arb_pkg holds:
  - register offset localparams (REG_START, REG_CLKDIV, REG_SADDR, REG_TXDATA, REG_RXDATA, REG_STATUS, REG_MODE);
  - STATUS_DONE_BIT = 0;
  - the state enum typedef.
- One sub-module, rr_arbiter: NUM_REQ requests plus pointer in, one-hot grant and id out, combinational.

Test Plan:
- Req0 write, addr 7'h50, wdata 8'hA5; master model sets done after 3 polls -> bus writes in order 0x04=8, 0x08=0x50, 0x0C=0xA5, 0x18=0, 0x14=0, 0x00=1, then 0x00=0, 0x14=0; rsp_valid with id=0, rdata=0, err=0.
- Req2 read, addr 7'h3C; model returns rx 8'h5E at 0x10 -> 0x18=1 written, 0x10 read after done, rsp_rdata=8'h5E, rsp_id=2.
- All 4 req held high for 8 transactions -> rsp_id sequence 0,1,2,3,0,1,2,3; never two transactions overlapping.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=10, done never set -> exactly 10 poll misses, then 0x00=0, 0x14=0, rsp_err=1, rsp_rdata=0. Without the macro, still polling after 1000 cycles.
- rst_n low during POLL -> all outputs 0 within the reset, busy=0; after release, a pending req3 restarts from W_DIV.
- Req1 dropped in W_ADDR -> transaction completes; rsp_valid with id=1.

Source files
------------

// File: rtl/i2c_txn_arbiter_pkg.sv
// Shared definitions for the I2C transaction arbiter: master register map,
// status bit position and the sequencing state encoding.
// No ports; imported by i2c_txn_arbiter and rr_arbiter.
package i2c_arb_pkg;

  // I2C master register offsets (byte addresses on the 32-bit register port)
  localparam logic [7:0] REG_START  = 8'h00;
  localparam logic [7:0] REG_CLKDIV = 8'h04;
  localparam logic [7:0] REG_SADDR  = 8'h08;
  localparam logic [7:0] REG_TXDATA = 8'h0C;
  localparam logic [7:0] REG_RXDATA = 8'h10;
  localparam logic [7:0] REG_STATUS = 8'h14;
  localparam logic [7:0] REG_MODE   = 8'h18;

  localparam int STATUS_DONE_BIT = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_DIV,
    S_W_ADDR,
    S_W_DATA,
    S_W_MODE,
    S_W_CLR,
    S_W_START,
    S_POLL,
    S_POLL_CHK,
    S_RD_REQ,
    S_RD_CAP,
    S_W_STOP,
    S_W_DONECLR,
    S_RESP
  } state_t;

endpackage

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping past NUM_REQ-1 back to 0.
// Ports: req (requests), ptr (search start) in; grant (one-hot), id, any out.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  int unsigned idx;

  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        id         = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master register port between NUM_REQ requesters: round-robin
// grant, programs the master, polls done, fetches rx byte on reads, responds.
// Ports: clk/rst_n; req/req_addr/req_rw/req_wdata from requesters;
//   rsp_valid/rsp_id/rsp_rdata/rsp_err/busy back; m_wr/m_addr_offset/
//   m_data_in/m_data_out to the master register port.
// Optional macro I2C_ARB_TIMEOUT_EN: abort after TIMEOUT_CYCLES poll misses.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int          NUM_REQ        = 4,
  parameter logic [7:0]  CLK_DIV_VAL    = 8'd8,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535,
  parameter int          ID_W           = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*7-1:0] req_addr,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 m_wr,
  output logic [7:0]           m_addr_offset,
  output logic [31:0]          m_data_in,
  input  logic [31:0]          m_data_out
);

  state_t state, nxt;

  logic [ID_W-1:0]    ptr, lat_id, arb_id;
  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_any;
  logic [6:0]         lat_addr, sel_addr;
  logic               lat_rw, sel_rw;
  logic [7:0]         lat_wdata, sel_wdata, rdata_q;
  logic               done_bit;

  logic               wr_d, rv_d;
  logic [7:0]         off_d;
  logic [31:0]        din_d;
  logic [ID_W-1:0]    rid_d;
  logic [7:0]         rdat_d;

  logic unused_bits;
  assign unused_bits = ^m_data_out[31:8];

  assign done_bit = m_data_out[STATUS_DONE_BIT];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .id    (arb_id),
    .any   (arb_any)
  );

  // One-hot mux of the winner's transaction fields
  always_comb begin
    sel_addr  = '0;
    sel_rw    = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_addr  = req_addr[7*i +: 7];
        sel_rw    = req_rw[i];
        sel_wdata = req_wdata[8*i +: 8];
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] tcnt;
  logic        err_q;
  logic        timeout_hit;
  // This miss is the TIMEOUT_CYCLES-th one
  assign timeout_hit = (tcnt == TIMEOUT_CYCLES - 16'd1);
`else
  localparam logic [15:0] UNUSED_TIMEOUT = TIMEOUT_CYCLES;
`endif

  // Next state plus next-cycle bus/response values. Outputs are registered
  // from the next state so they line up with the state and are 0 in reset.
  always_comb begin
    nxt    = state;
    wr_d   = 1'b0;
    off_d  = REG_STATUS;
    din_d  = '0;
    rv_d   = 1'b0;
    rid_d  = '0;
    rdat_d = '0;

    case (state)
      S_IDLE:      if (arb_any) nxt = S_W_DIV;
      S_W_DIV:     nxt = S_W_ADDR;
      S_W_ADDR:    nxt = S_W_DATA;
      S_W_DATA:    nxt = S_W_MODE;
      S_W_MODE:    nxt = S_W_CLR;
      S_W_CLR:     nxt = S_W_START;
      S_W_START:   nxt = S_POLL;
      S_POLL:      nxt = S_POLL_CHK;
      S_POLL_CHK: begin
        if (done_bit) nxt = lat_rw ? S_RD_REQ : S_W_STOP;
`ifdef I2C_ARB_TIMEOUT_EN
        else if (timeout_hit) nxt = S_W_STOP;
`endif
        else nxt = S_POLL;
      end
      S_RD_REQ:    nxt = S_RD_CAP;
      S_RD_CAP:    nxt = S_W_STOP;
      S_W_STOP:    nxt = S_W_DONECLR;
      S_W_DONECLR: nxt = S_RESP;
      S_RESP:      nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase

    case (nxt)
      S_W_DIV:     begin wr_d = 1'b1; off_d = REG_CLKDIV; din_d = {24'd0, CLK_DIV_VAL}; end
      S_W_ADDR:    begin wr_d = 1'b1; off_d = REG_SADDR;  din_d = {25'd0, lat_addr};    end
      S_W_DATA:    begin wr_d = 1'b1; off_d = REG_TXDATA; din_d = {24'd0, lat_wdata};   end
      S_W_MODE:    begin wr_d = 1'b1; off_d = REG_MODE;   din_d = {31'd0, lat_rw};      end
      S_W_CLR:     begin wr_d = 1'b1; off_d = REG_STATUS; end
      S_W_START:   begin wr_d = 1'b1; off_d = REG_START;  din_d = 32'd1; end
      S_RD_REQ:    off_d = REG_RXDATA;
      S_W_STOP:    begin wr_d = 1'b1; off_d = REG_START;  end
      S_W_DONECLR: begin wr_d = 1'b1; off_d = REG_STATUS; end
      S_RESP:      begin rv_d = 1'b1; rid_d = lat_id; rdat_d = rdata_q; end
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      lat_id    <= '0;
      lat_addr  <= '0;
      lat_rw    <= 1'b0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && arb_any) begin
        lat_id    <= arb_id;
        lat_addr  <= sel_addr;
        lat_rw    <= sel_rw;
        lat_wdata <= sel_wdata;
        // Cleared at grant: writes and aborted reads report 0
        rdata_q   <= '0;
        ptr       <= (arb_id == ID_W'(NUM_REQ - 1)) ? '0 : arb_id + 1'b1;
      end
      if (state == S_RD_CAP) rdata_q <= m_data_out[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr          <= 1'b0;
      m_addr_offset <= '0;
      m_data_in     <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_rdata     <= '0;
      busy          <= 1'b0;
    end else begin
      m_wr          <= wr_d;
      m_addr_offset <= off_d;
      m_data_in     <= din_d;
      rsp_valid     <= rv_d;
      rsp_id        <= rid_d;
      rsp_rdata     <= rdat_d;
      busy          <= (nxt != S_IDLE);
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  // rdata needs no clearing on abort: it was zeroed at grant and the
  // read states are skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt    <= '0;
      err_q   <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (state == S_IDLE && arb_any) err_q <= 1'b0;
      if (state == S_W_START) tcnt <= '0;
      if (state == S_POLL_CHK && !done_bit) begin
        if (timeout_hit) err_q <= 1'b1;
        else             tcnt  <= tcnt + 16'd1;
      end
      rsp_err <= (nxt == S_RESP) && err_q;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
module tb_i2c_txn_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [27:0] req_addr;
  logic [3:0]  req_rw;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        m_wr;
  logic [7:0]  m_addr_offset;
  logic [31:0] m_data_in;
  logic [31:0] m_data_out = '0;

  always #5 clk = ~clk;

  i2c_txn_arbiter #(
    .NUM_REQ(4), .CLK_DIV_VAL(8'd8), .TIMEOUT_CYCLES(16'd10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .m_wr(m_wr),
    .m_addr_offset(m_addr_offset), .m_data_in(m_data_in), .m_data_out(m_data_out)
  );

  typedef struct packed { logic [7:0] off; logic [31:0] dat; } wr_t;
  typedef struct packed { logic [1:0] id; logic [7:0] rdata; logic err; } rsp_t;

  wr_t  exp_wr[$];
  rsp_t exp_rsp[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_start = 0, t_stop = 0;
  int rx_reads = 0;
  int rsp_seen = 0;

  // Master model: done_delay cycles after start=1, status done is set
  // (0 = never). instant_done forces done on every status read.
  int          done_delay = 0;
  bit          instant_done = 0;
  logic [7:0]  rx_value = 8'h00;
  logic [31:0] status_q = '0;
  int          timer = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (timer == 1) status_q <= 32'd1;
    if (timer > 0) timer <= timer - 1;
    if (m_wr) begin
      if (m_addr_offset == 8'h00 && m_data_in[0] && done_delay > 0) timer <= done_delay;
      if (m_addr_offset == 8'h14) status_q <= m_data_in;
      m_data_out <= '0;
    end else begin
      case (m_addr_offset)
        8'h14:   m_data_out <= status_q | {31'd0, instant_done};
        8'h10:   m_data_out <= {24'd0, rx_value};
        default: m_data_out <= '0;
      endcase
    end
  end

  function automatic void push_writes(input logic [6:0] a, input logic [7:0] d,
                                      input logic rw, input bit full);
    exp_wr.push_back('{8'h04, 32'd8});
    exp_wr.push_back('{8'h08, {25'd0, a}});
    exp_wr.push_back('{8'h0C, {24'd0, d}});
    exp_wr.push_back('{8'h18, {31'd0, rw}});
    exp_wr.push_back('{8'h14, 32'd0});
    exp_wr.push_back('{8'h00, 32'd1});
    if (full) begin
      exp_wr.push_back('{8'h00, 32'd0});
      exp_wr.push_back('{8'h14, 32'd0});
    end
  endfunction

  // One cycle of scoreboard monitoring, sampled on the falling edge
  task automatic sample_cycle();
    wr_t  w;
    rsp_t r;
    @(negedge clk);
    if (m_wr) begin
      total++;
      if (exp_wr.size() == 0) begin
        bad++;
        $display("FAIL bus_write unexpected off=%h dat=%h", m_addr_offset, m_data_in);
      end else begin
        w = exp_wr.pop_front();
        if (m_addr_offset !== w.off || m_data_in !== w.dat) begin
          bad++;
          $display("FAIL bus_write got off=%h dat=%h want off=%h dat=%h",
                   m_addr_offset, m_data_in, w.off, w.dat);
        end
      end
      if (m_addr_offset == 8'h00 && m_data_in == 32'd1) t_start = cyc;
      if (m_addr_offset == 8'h00 && m_data_in == 32'd0) t_stop = cyc;
    end else if (rst_n) begin
      total++;
      if (m_data_in !== 32'd0 || (m_addr_offset !== 8'h14 && m_addr_offset !== 8'h10)) begin
        bad++;
        $display("FAIL bus_read_idle got off=%h dat=%h want off=14/10 dat=0",
                 m_addr_offset, m_data_in);
      end
      if (m_addr_offset == 8'h10) rx_reads++;
    end
    if (rsp_valid) begin
      rsp_seen++;
      total++;
      if (exp_rsp.size() == 0) begin
        bad++;
        $display("FAIL rsp unexpected id=%0d rdata=%h err=%b", rsp_id, rsp_rdata, rsp_err);
      end else begin
        r = exp_rsp.pop_front();
        if (rsp_id !== r.id || rsp_rdata !== r.rdata || rsp_err !== r.err) begin
          bad++;
          $display("FAIL rsp got id=%0d rdata=%h err=%b want id=%0d rdata=%h err=%b",
                   rsp_id, rsp_rdata, rsp_err, r.id, r.rdata, r.err);
        end
      end
    end
  endtask

  task automatic wait_rsp(input int n, input int budget, output bit ok);
    int start;
    start = rsp_seen;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      sample_cycle();
      if (rsp_seen - start >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    exp_wr.delete();
    exp_rsp.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({m_wr, m_addr_offset, m_data_in, rsp_valid, rsp_id, rsp_rdata, rsp_err, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got wr=%b off=%h din=%h busy=%b want all 0",
               m_wr, m_addr_offset, m_data_in, busy);
    end
    rst_n = 1'b1;
    repeat (2) sample_cycle();
    total++;
    if (busy !== 1'b0 || m_wr !== 1'b0 || m_addr_offset !== 8'h14) begin
      bad++;
      $display("FAIL idle_bus got busy=%b wr=%b off=%h want 0 0 14", busy, m_wr, m_addr_offset);
    end
  endtask

  task automatic test_write();
    bit ok;
    done_delay = 4;
    req_addr[6:0] = 7'h50; req_wdata[7:0] = 8'hA5; req_rw[0] = 1'b0;
    push_writes(7'h50, 8'hA5, 1'b0, 1'b1);
    exp_rsp.push_back('{2'd0, 8'h00, 1'b0});
    req[0] = 1'b1;
    sample_cycle();
    total++;
    if (m_wr !== 1'b1 || m_addr_offset !== 8'h04) begin
      bad++;
      $display("FAIL grant_latency got wr=%b off=%h want 1 04", m_wr, m_addr_offset);
    end
    wait_rsp(1, 100, ok);
    req[0] = 1'b0;
    total++;
    if (!ok || exp_wr.size() != 0) begin
      bad++;
      $display("FAIL write_done got ok=%0d left=%0d want 1 0", ok, exp_wr.size());
    end
    total++;
    if (t_stop - t_start != 7) begin
      bad++;
      $display("FAIL poll_3_gap got %0d want 7", t_stop - t_start);
    end
  endtask

  task automatic test_read();
    bit ok;
    done_delay = 1; rx_value = 8'h5E; rx_reads = 0;
    req_addr[20:14] = 7'h3C; req_wdata[23:16] = 8'h11; req_rw[2] = 1'b1;
    push_writes(7'h3C, 8'h11, 1'b1, 1'b1);
    exp_rsp.push_back('{2'd2, 8'h5E, 1'b0});
    req[2] = 1'b1;
    wait_rsp(1, 100, ok);
    req[2] = 1'b0;
    total++;
    if (!ok || exp_wr.size() != 0) begin
      bad++;
      $display("FAIL read_done got ok=%0d left=%0d want 1 0", ok, exp_wr.size());
    end
    total++;
    if (rx_reads != 1) begin
      bad++;
      $display("FAIL rx_read_count got %0d want 1", rx_reads);
    end
  endtask

  task automatic test_drop();
    int w_div_c, rsp_c;
    bit seen;
    instant_done = 1; w_div_c = -100; rsp_c = 0; seen = 0;
    req_addr[13:7] = 7'h0A; req_wdata[15:8] = 8'h5A; req_rw[1] = 1'b0;
    push_writes(7'h0A, 8'h5A, 1'b0, 1'b1);
    exp_rsp.push_back('{2'd1, 8'h00, 1'b0});
    req[1] = 1'b1;
    for (int i = 0; i < 60 && !seen; i++) begin
      sample_cycle();
      if (m_wr && m_addr_offset == 8'h04) w_div_c = i;
      if (m_wr && m_addr_offset == 8'h08) req[1] = 1'b0;
      if (rsp_valid) begin seen = 1; rsp_c = i; end
    end
    instant_done = 0;
    total++;
    if (!seen || rsp_c - w_div_c != 10) begin
      bad++;
      $display("FAIL drop_rsp_latency got seen=%0d lat=%0d want 1 10", seen, rsp_c - w_div_c);
    end
    sample_cycle();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    apply_reset();
    done_delay = 2;
    for (int i = 0; i < 4; i++) begin
      req_addr[7*i +: 7]  = 7'h10 + 7'(i);
      req_wdata[8*i +: 8] = 8'hC0 + 8'(i);
    end
    req_rw = '0;
    for (int k = 0; k < 8; k++) begin
      push_writes(7'h10 + 7'(k % 4), 8'hC0 + 8'(k % 4), 1'b0, 1'b1);
      exp_rsp.push_back('{2'(k % 4), 8'h00, 1'b0});
    end
    req = 4'hF;
    wait_rsp(8, 600, ok);
    req = '0;
    repeat (4) sample_cycle();
    total++;
    if (!ok || exp_rsp.size() != 0 || exp_wr.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rr_sequence got ok=%0d rsp_left=%0d wr_left=%0d busy=%b want 1 0 0 0",
               ok, exp_rsp.size(), exp_wr.size(), busy);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int seen0;
    done_delay = 0;
    req_addr[6:0] = 7'h22; req_wdata[7:0] = 8'h33; req_rw[0] = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    push_writes(7'h22, 8'h33, 1'b0, 1'b1);
    exp_rsp.push_back('{2'd0, 8'h00, 1'b1});
    req[0] = 1'b1;
    wait_rsp(1, 200, ok);
    req[0] = 1'b0;
    total++;
    if (!ok || exp_wr.size() != 0) begin
      bad++;
      $display("FAIL timeout_done got ok=%0d left=%0d want 1 0", ok, exp_wr.size());
    end
    total++;
    if (t_stop - t_start != 21) begin
      bad++;
      $display("FAIL timeout_gap got %0d want 21", t_stop - t_start);
    end
    seen0 = 0;
`else
    ok = 0;
    push_writes(7'h22, 8'h33, 1'b0, 1'b0);
    req[0] = 1'b1;
    seen0 = rsp_seen;
    repeat (1000) sample_cycle();
    total++;
    if (busy !== 1'b1 || rsp_seen != seen0 || exp_wr.size() != 0 || ok) begin
      bad++;
      $display("FAIL still_polling got busy=%b rsps=%0d left=%0d want 1 0 0",
               busy, rsp_seen - seen0, exp_wr.size());
    end
    req[0] = 1'b0;
    apply_reset();
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    done_delay = 0;
    req_addr[27:21] = 7'h61; req_wdata[31:24] = 8'h9C; req_rw[3] = 1'b0;
    push_writes(7'h61, 8'h9C, 1'b0, 1'b0);
    req[3] = 1'b1;
    for (int i = 0; i < 50 && exp_wr.size() != 0; i++) sample_cycle();
    repeat (3) sample_cycle();
    rst_n = 1'b0;
    #1;
    total++;
    if ({m_wr, m_addr_offset, m_data_in, rsp_valid, rsp_id, rsp_rdata, rsp_err, busy} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs got wr=%b off=%h busy=%b want all 0",
               m_wr, m_addr_offset, busy);
    end
    @(negedge clk);
    exp_wr.delete();
    exp_rsp.delete();
    done_delay = 2;
    push_writes(7'h61, 8'h9C, 1'b0, 1'b1);
    exp_rsp.push_back('{2'd3, 8'h00, 1'b0});
    rst_n = 1'b1;
    sample_cycle();
    total++;
    if (m_wr !== 1'b1 || m_addr_offset !== 8'h04) begin
      bad++;
      $display("FAIL restart_w_div got wr=%b off=%h want 1 04", m_wr, m_addr_offset);
    end
    wait_rsp(1, 100, ok);
    req[3] = 1'b0;
    total++;
    if (!ok || exp_wr.size() != 0) begin
      bad++;
      $display("FAIL restart_done got ok=%0d left=%0d want 1 0", ok, exp_wr.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_drop();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (3) sample_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
